// File: rtl/sx_pkg.sv
// Shared types and helpers for the sx_demux ingress routing stage.
package sx_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FWD  = 2'd1,
    DROP = 2'd2
  } sx_state_e;

  localparam int SX_DATA_WIDTH = 64;
  localparam int SX_KEEP_WIDTH = SX_DATA_WIDTH / 8;

  typedef struct packed {
    logic [SX_DATA_WIDTH-1:0] data;
    logic [SX_KEEP_WIDTH-1:0] keep;
    logic                     last;
  } sx_beat_t;

  // True when m ports fit in a dw-bit destination field and m is in the supported range.
  function automatic bit sx_dest_width_ok(input int m, input int dw);
    return (m >= 2) && (m <= 16) && ((1 << dw) >= m);
  endfunction

endpackage

// File: rtl/sx_out_slice.sv
// Single-entry registered AXI-Stream output stage; one per master port.
module sx_out_slice #(
  parameter int DATA_WIDTH = 64
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    load_i,
  input  logic [DATA_WIDTH-1:0]   data_i,
  input  logic [DATA_WIDTH/8-1:0] keep_i,
  input  logic                    last_i,
  input  logic                    ready_i,
  output logic                    valid_o,
  output logic [DATA_WIDTH-1:0]   data_o,
  output logic [DATA_WIDTH/8-1:0] keep_o,
  output logic                    last_o
);

  logic                    valid_q;
  logic [DATA_WIDTH-1:0]   data_q;
  logic [DATA_WIDTH/8-1:0] keep_q;
  logic                    last_q;

  // The top only loads when the slot is empty or draining, so payload stays stable while stalled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      keep_q  <= '0;
      last_q  <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
      keep_q  <= keep_i;
      last_q  <= last_i;
    end else if (ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign keep_o  = keep_q;
  assign last_o  = last_q;

endmodule

// File: rtl/sx_demux.sv
// AXI-Stream demux: steers whole packets to a master port chosen by tdest on the first beat.
module sx_demux
  import sx_pkg::*;
#(
  parameter int M_DATA_COUNT = 10,
  parameter int DATA_WIDTH   = 64,
  parameter int DEST_WIDTH   = $clog2(M_DATA_COUNT)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [DATA_WIDTH-1:0]   s_axis_data_i,
  input  logic [DATA_WIDTH/8-1:0] s_axis_keep_i,
  input  logic                    s_axis_last_i,
  input  logic [DEST_WIDTH-1:0]   s_axis_dest_i,
  input  logic                    s_axis_valid_i,
  output logic                    s_axis_ready_o,
  output logic [DATA_WIDTH-1:0]   m_axis_data_o [M_DATA_COUNT],
  output logic [DATA_WIDTH/8-1:0] m_axis_keep_o [M_DATA_COUNT],
  output logic [M_DATA_COUNT-1:0] m_axis_last_o,
  output logic [M_DATA_COUNT-1:0] m_axis_valid_o,
  input  logic [M_DATA_COUNT-1:0] m_axis_ready_i,
  output logic                    drop_o
);

  if (!sx_dest_width_ok(M_DATA_COUNT, DEST_WIDTH) || (DATA_WIDTH % 8 != 0)) begin : g_param_err
    $error("sx_demux: unsupported M_DATA_COUNT/DEST_WIDTH/DATA_WIDTH combination");
  end

  localparam logic [DEST_WIDTH:0] M_CNT = (DEST_WIDTH + 1)'(M_DATA_COUNT);

  sx_state_e               state_q, state_d;
  logic [DEST_WIDTH-1:0]   route_q, route_d;
  logic                    drop_q, drop_d;
  logic [DEST_WIDTH-1:0]   sel;
  logic                    fwd, discard, dest_ok, port_free, s_ready, accept;
  logic [M_DATA_COUNT-1:0] load;

  assign dest_ok = ({1'b0, s_axis_dest_i} < M_CNT);

  // sel only takes s_axis_dest_i when it is in range, so indexing by sel is always legal.
  always_comb begin
    fwd     = 1'b0;
    discard = 1'b0;
    sel     = route_q;
    case (state_q)
      IDLE: begin
        if (dest_ok) begin
          fwd = 1'b1;
          sel = s_axis_dest_i;
        end else begin
          discard = 1'b1;
        end
      end
      FWD:     fwd = 1'b1;
      DROP:    discard = 1'b1;
      default: ;
    endcase
  end

  assign port_free      = !m_axis_valid_o[sel] || m_axis_ready_i[sel];
  assign s_ready        = reset_n && (discard || (fwd && port_free));
  assign s_axis_ready_o = s_ready;
  assign accept         = s_axis_valid_i && s_ready;

  always_comb begin
    state_d = state_q;
    route_d = route_q;
    drop_d  = 1'b0;
    if (accept) begin
      case (state_q)
        IDLE: begin
          if (s_axis_last_i) begin
            drop_d = discard;
          end else if (discard) begin
            state_d = DROP;
          end else begin
            state_d = FWD;
            route_d = s_axis_dest_i;
          end
        end
        FWD: begin
          if (s_axis_last_i) state_d = IDLE;
        end
        DROP: begin
          if (s_axis_last_i) begin
            drop_d  = 1'b1;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      route_q <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      route_q <= route_d;
      drop_q  <= drop_d;
    end
  end

  assign drop_o = drop_q;

  for (genvar p = 0; p < M_DATA_COUNT; p++) begin : g_slice
    assign load[p] = accept && fwd && (sel == DEST_WIDTH'(p));

    sx_out_slice #(
      .DATA_WIDTH(DATA_WIDTH)
    ) u_slice (
      .clk     (clk),
      .reset_n (reset_n),
      .load_i  (load[p]),
      .data_i  (s_axis_data_i),
      .keep_i  (s_axis_keep_i),
      .last_i  (s_axis_last_i),
      .ready_i (m_axis_ready_i[p]),
      .valid_o (m_axis_valid_o[p]),
      .data_o  (m_axis_data_o[p]),
      .keep_o  (m_axis_keep_o[p]),
      .last_o  (m_axis_last_o[p])
    );
  end

endmodule

// File: doc/sx_demux.md
Name: sx_demux

Overview:
- Ingress routing stage of the AXI-Stream switch; sits directly upstream of sx_mux.
- Takes one slave AXI-Stream port and steers each whole packet to one of M_DATA_COUNT master ports, selected by tdest.
- tdest is sampled on the first beat of a packet and the route is locked until the beat with last.
- Packets with an out-of-range tdest are consumed and discarded. Each master output is a registered slice, so there is 1-cycle forwarding latency.

Parameters:
- M_DATA_COUNT, 10, number of master (output) ports, 2..16
- DATA_WIDTH, 64, tdata width in bits, multiple of 8
- DEST_WIDTH, $clog2(M_DATA_COUNT), tdest width; must satisfy 2**DEST_WIDTH >= M_DATA_COUNT

Ports:
- clk  in  1  clock, rising-edge
- reset_n  in  1  asynchronous, active-low reset
- s_axis_data_i  in  DATA_WIDTH  slave tdata
- s_axis_keep_i  in  DATA_WIDTH/8  slave tkeep
- s_axis_last_i  in  1  slave tlast
- s_axis_dest_i  in  DEST_WIDTH  slave tdest; meaningful on the first beat only
- s_axis_valid_i  in  1  slave tvalid
- s_axis_ready_o  out  1  slave tready
- m_axis_data_o  out  [M_DATA_COUNT][DATA_WIDTH]  master tdata, per port
- m_axis_keep_o  out  [M_DATA_COUNT][DATA_WIDTH/8]  master tkeep
- m_axis_last_o  out  [M_DATA_COUNT]  master tlast
- m_axis_valid_o  out  [M_DATA_COUNT]  master tvalid
- m_axis_ready_i  in  [M_DATA_COUNT]  master tready
- drop_o  out  1  one-cycle pulse when the last beat of a discarded packet is consumed

Behaviour:
- Reset (reset_n low, asynchronous):
  - All m_axis_valid_o = 0; m_axis_data/keep/last registers = 0.
  - drop_o = 0; FSM = IDLE; route register = 0.
  - s_axis_ready_o = 0 while reset is asserted.
- FSM states are IDLE, FWD and DROP.
  - IDLE: the next accepted beat is a first beat. The route is taken combinationally from s_axis_dest_i.
    - dest < M_DATA_COUNT: the beat goes to port dest.
    - dest >= M_DATA_COUNT: the beat is discarded.
    - Next state: if last = 1, stay in IDLE (single-beat packet, drop_o pulses when discarded). Otherwise go to FWD, or to DROP when discarded, and latch the route.
  - FWD: beats go to the latched port; s_axis_dest_i is ignored. An accepted beat with last = 1 returns the FSM to IDLE.
  - DROP: s_axis_ready_o = 1; beats are discarded. An accepted beat with last = 1 pulses drop_o for 1 cycle and returns the FSM to IDLE.
- Ready rule when forwarding to port p: s_axis_ready_o = !m_axis_valid_o[p] || m_axis_ready_i[p].
  - This is a combinational path from m_axis_ready_i to s_axis_ready_o by design; there is no skid buffer.
- Output slice p:
  - On an accepted beat routed to p: load data/keep/last and set valid = 1 on the next edge. This gives 1-cycle latency.
  - Cleared when m_axis_ready_i[p] = 1 and no new beat is loaded.
  - Load and drain in the same cycle: the output keeps valid = 1 and holds the new beat.
- Only the routed port changes. Other ports keep draining independently.
- Only one master valid can be newly set per cycle.
- AXI rule: once m_axis_valid_o[p] = 1, data/keep/last are stable until m_axis_ready_i[p] = 1.
- Backpressure: while the routed port is stalled, s_axis_ready_o = 0 and there is no data loss.
- The route never switches mid-packet, even if s_axis_dest_i changes.
- Reset mid-packet: all state is cleared, the partial packet is abandoned, and the next beat after reset is treated as a first beat.

Decomposition:
- Shared package sx_pkg:
  - FSM enum typedef: IDLE/FWD/DROP.
  - Helper function for clog2-based DEST_WIDTH checks.
  - Common AXIS beat struct: data, keep, last, parameterised via DATA_WIDTH localparams.
- Sub-module sx_out_slice: single-entry registered AXIS output stage, instantiated M_DATA_COUNT times with a generate loop.
- The top-level module contains the FSM, route register and ready/valid steering.

Test Plan:
- 3-beat packet, dest = 4, all m_ready = 1 -> beats appear on port 4 only, one cycle after each acceptance; last on beat 3; all other valids stay 0.
- dest = 2 on beat 1, then dest driven to 7 on beats 2-4 -> all 4 beats appear on port 2; port 7 valid is never set.
- dest = 12 (out of range, M = 10), 5-beat packet -> s_ready = 1 throughout, no master valid asserted, drop_o = 1 exactly on the cycle after beat 5 is accepted.
- Port 1 m_ready held 0 for 6 cycles during a 4-beat packet -> s_ready drops to 0 after the first beat is captured, and the data on port 1 is held stable. Once m_ready is released, beats flow and all 4 arrive in order.
- Back-to-back single-beat packets with dest 0, 9, 0, 9 and all ready -> alternate ports receive beats on consecutive cycles with no bubble.
- reset_n pulsed low during beat 2 of a 4-beat packet to port 3 -> all valids drop to 0 immediately. The next beat (dest = 5) is routed to port 5 as a new packet.
